// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts tagged ALU commands over valid/ready, issues one
// operation at a time to a registered ALU, waits out its latency and returns
// the captured result, flags and tag on a valid/ready response stream.
module alu_cmd_issuer #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int ALU_LAT    = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   input  logic [3:0]            cmd_op,
   input  logic [TAG_WIDTH-1:0]  cmd_tag,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [3:0]            alu_opcode,
   output logic                  alu_enable,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_overflow,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_overflow,
   output logic                  rsp_err,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic [CNT_WIDTH-1:0]  issued_cnt
);

   localparam int WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [WCW-1:0]  wait_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic            accept;
   logic            illegal;
   logic            wait_last;

   assign accept    = (state_q == S_IDLE) && cmd_valid;
   assign illegal   = cmd_op[3];
   assign wait_last = (state_q == S_WAIT) && (wait_q == WCW'(ALU_LAT - 1));

   // State register; async reset so alu_enable drops the moment rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake/enable outputs decoded from the current state.
   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      alu_enable = 1'b0;
      rsp_valid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = illegal ? S_RESP : S_ISSUE;
         end
         S_ISSUE: begin
            alu_enable = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (wait_last) state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command latch: operands/opcode/tag held stable on the ALU side until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         tag_q      <= '0;
      end else if (accept) begin
         alu_a      <= cmd_a;
         alu_b      <= cmd_b;
         alu_opcode <= cmd_op;
         tag_q      <= cmd_tag;
      end
   end

   // Latency counter across the WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  wait_q <= '0;
      else if (state_q == S_WAIT)  wait_q <= wait_last ? '0 : wait_q + 1'b1;
      else                         wait_q <= '0;
   end

   // Response payload: loaded by an illegal accept or by the last WAIT edge, then frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result   <= '0;
         rsp_zero     <= 1'b1;
         rsp_overflow <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_tag      <= '0;
      end else if (accept && illegal) begin
         rsp_result   <= '0;
         rsp_zero     <= 1'b1;
         rsp_overflow <= 1'b0;
         rsp_err      <= 1'b1;
         rsp_tag      <= cmd_tag;
      end else if (wait_last) begin
         rsp_result   <= alu_result;
         rsp_zero     <= (alu_result == '0);
         rsp_overflow <= alu_overflow;
         rsp_err      <= 1'b0;
         rsp_tag      <= tag_q;
      end
   end

   // Issued-operation counter; bumps on the edge leaving ISSUE, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   issued_cnt <= '0;
      else if (state_q == S_ISSUE)  issued_cnt <= issued_cnt + 1'b1;
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer: one instance with ALU_LAT=1 and one
// with ALU_LAT=3 / CNT_WIDTH=3, each driving a registered ALU stand-in whose
// result is only present in the exact cycle it is due.
module tb_alu_cmd_issuer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- instance 1: ALU_LAT=1 ----------------
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic [3:0]  cmd_op = '0, cmd_tag = '0;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_opcode;
   logic        alu_enable, alu_overflow;
   logic        rsp_valid, rsp_ready = 1'b1;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_overflow, rsp_err;
   logic [3:0]  rsp_tag;
   logic [15:0] issued_cnt;

   alu_cmd_issuer #(.DATA_WIDTH(32), .TAG_WIDTH(4), .ALU_LAT(1), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
      .rsp_tag(rsp_tag), .issued_cnt(issued_cnt)
   );

   // ---------------- instance 2: ALU_LAT=3, CNT_WIDTH=3 ----------------
   logic        t3_cmd_valid = 1'b0, t3_cmd_ready;
   logic [31:0] t3_cmd_a = '0, t3_cmd_b = '0;
   logic [3:0]  t3_cmd_op = '0, t3_cmd_tag = '0;
   logic [31:0] t3_alu_a, t3_alu_b, t3_alu_result;
   logic [3:0]  t3_alu_opcode;
   logic        t3_alu_enable, t3_alu_overflow;
   logic        t3_rsp_valid, t3_rsp_ready = 1'b1;
   logic [31:0] t3_rsp_result;
   logic        t3_rsp_zero, t3_rsp_overflow, t3_rsp_err;
   logic [3:0]  t3_rsp_tag;
   logic [2:0]  t3_issued_cnt;

   alu_cmd_issuer #(.DATA_WIDTH(32), .TAG_WIDTH(4), .ALU_LAT(3), .CNT_WIDTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(t3_cmd_valid), .cmd_ready(t3_cmd_ready), .cmd_a(t3_cmd_a), .cmd_b(t3_cmd_b),
      .cmd_op(t3_cmd_op), .cmd_tag(t3_cmd_tag),
      .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_opcode(t3_alu_opcode), .alu_enable(t3_alu_enable),
      .alu_result(t3_alu_result), .alu_overflow(t3_alu_overflow),
      .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready), .rsp_result(t3_rsp_result),
      .rsp_zero(t3_rsp_zero), .rsp_overflow(t3_rsp_overflow), .rsp_err(t3_rsp_err),
      .rsp_tag(t3_rsp_tag), .issued_cnt(t3_issued_cnt)
   );

   // ---------------- ALU stand-ins ----------------
   function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      logic [31:0] r;
      logic        ov;
      ov = 1'b0;
      case (op)
         4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << b[4:0];
         4'd6: r = a >> b[4:0];
         4'd7: r = $signed(a) >>> b[4:0];
         default: r = '0;
      endcase
      return {ov, r};
   endfunction

   logic [32:0] p1, q1, q2, q3;
   always_ff @(posedge clk) begin
      p1 <= alu_enable ? alu_f(alu_a, alu_b, alu_opcode) : '0;
      q1 <= t3_alu_enable ? alu_f(t3_alu_a, t3_alu_b, t3_alu_opcode) : '0;
      q2 <= q1;
      q3 <= q2;
   end
   assign {alu_overflow, alu_result}       = p1;
   assign {t3_alu_overflow, t3_alu_result} = q3;

   int en_cnt = 0;
   always_ff @(posedge clk) if (alu_enable) en_cnt <= en_cnt + 1;

   // Drive one command into instance 1 and count negedges until rsp_valid (99 = timeout).
   task automatic do_cmd1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [3:0] tag, output int lat);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
      lat = 99;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 1) cmd_valid = 1'b0;
         if (rsp_valid) begin lat = n; break; end
      end
   endtask

   task automatic do_cmd3(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [3:0] tag, output int lat);
      @(negedge clk);
      t3_cmd_valid = 1'b1; t3_cmd_a = a; t3_cmd_b = b; t3_cmd_op = op; t3_cmd_tag = tag;
      lat = 99;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 1) t3_cmd_valid = 1'b0;
         if (t3_rsp_valid) begin lat = n; break; end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      tests++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL reset_alu_enable: got %b want 0", alu_enable); end
      tests++; if ({alu_a, alu_b, alu_opcode} !== 68'd0) begin fails++; $display("FAIL reset_alu_bus: got %h want 0", {alu_a, alu_b, alu_opcode}); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      tests++; if ({rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag} !== {32'd0, 1'b1, 1'b0, 1'b0, 4'd0})
         begin fails++; $display("FAIL reset_rsp_payload: got %h/%b/%b/%b/%h want 0/1/0/0/0", rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag); end
      tests++; if (issued_cnt !== 16'd0) begin fails++; $display("FAIL reset_issued_cnt: got %0d want 0", issued_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add;
      int lat, en0;
      en0 = en_cnt;
      do_cmd1(32'd5, 32'd7, 4'd0, 4'd3, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL add_latency: got %0d want 3", lat); end
      tests++; if (rsp_result !== 32'd12) begin fails++; $display("FAIL add_result: got %0d want 12", rsp_result); end
      tests++; if ({rsp_zero, rsp_err, rsp_overflow} !== 3'b000) begin fails++; $display("FAIL add_flags: got %b want 000", {rsp_zero, rsp_err, rsp_overflow}); end
      tests++; if (rsp_tag !== 4'd3) begin fails++; $display("FAIL add_tag: got %0d want 3", rsp_tag); end
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL add_ready_in_resp: got %b want 0", cmd_ready); end
      tests++; if (en_cnt - en0 != 1) begin fails++; $display("FAIL add_enable_pulses: got %0d want 1", en_cnt - en0); end
      @(negedge clk);
      tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL add_retire: got valid/ready %b want 01", {rsp_valid, cmd_ready}); end
      tests++; if (issued_cnt !== 16'd1) begin fails++; $display("FAIL add_issued_cnt: got %0d want 1", issued_cnt); end
   endtask

   task automatic test_sub_zero;
      int lat;
      do_cmd1(32'd9, 32'd9, 4'd1, 4'd1, lat);
      tests++; if ({rsp_result, rsp_zero} !== {32'd0, 1'b1}) begin fails++; $display("FAIL sub_zero: got %h/%b want 0/1", rsp_result, rsp_zero); end
   endtask

   task automatic test_overflow;
      int lat;
      do_cmd1(32'h7FFF_FFFF, 32'd1, 4'd0, 4'd2, lat);
      tests++; if (rsp_result !== 32'h8000_0000) begin fails++; $display("FAIL ovf_result: got %h want 80000000", rsp_result); end
      tests++; if ({rsp_overflow, rsp_zero} !== 2'b10) begin fails++; $display("FAIL ovf_flags: got ov/zero %b want 10", {rsp_overflow, rsp_zero}); end
   endtask

   task automatic test_ops;
      logic [31:0] ta[3], tb_[3], te[3];
      logic [3:0]  to[3];
      int lat;
      ta[0] = 32'hFF00_FF00; tb_[0] = 32'h0FF0_0FF0; to[0] = 4'd4; te[0] = 32'hF0F0_F0F0;
      ta[1] = 32'h0000_0001; tb_[1] = 32'd31;        to[1] = 4'd5; te[1] = 32'h8000_0000;
      ta[2] = 32'h8000_0010; tb_[2] = 32'd4;         to[2] = 4'd7; te[2] = 32'hF800_0001;
      for (int i = 0; i < 3; i++) begin
         do_cmd1(ta[i], tb_[i], to[i], 4'(i + 8), lat);
         tests++; if ({rsp_result, rsp_tag} !== {te[i], 4'(i + 8)})
            begin fails++; $display("FAIL ops_%0d: got %h tag %0d want %h tag %0d", i, rsp_result, rsp_tag, te[i], i + 8); end
      end
      @(negedge clk);
      tests++; if (issued_cnt !== 16'd6) begin fails++; $display("FAIL ops_issued_cnt: got %0d want 6", issued_cnt); end
   endtask

   task automatic test_illegal;
      int lat, en0;
      en0 = en_cnt;
      do_cmd1(32'd1, 32'd2, 4'hA, 4'd5, lat);
      tests++; if (lat != 1) begin fails++; $display("FAIL illegal_latency: got %0d want 1", lat); end
      tests++; if ({rsp_err, rsp_result, rsp_zero, rsp_overflow, rsp_tag} !== {1'b1, 32'd0, 1'b1, 1'b0, 4'd5})
         begin fails++; $display("FAIL illegal_payload: got err %b res %h z %b ov %b tag %0d want 1 0 1 0 5", rsp_err, rsp_result, rsp_zero, rsp_overflow, rsp_tag); end
      @(negedge clk); @(negedge clk);
      tests++; if (en_cnt != en0) begin fails++; $display("FAIL illegal_enable: got %0d pulses want 0", en_cnt - en0); end
      tests++; if (issued_cnt !== 16'd6) begin fails++; $display("FAIL illegal_issued_cnt: got %0d want 6", issued_cnt); end
   endtask

   task automatic test_stall;
      int lat;
      logic bad;
      rsp_ready = 1'b0;
      do_cmd1(32'd1, 32'd2, 4'd0, 4'd6, lat);
      bad = (lat != 3);
      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd100; cmd_b = 32'd100; cmd_tag = 4'd9;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_result !== 32'd3 || rsp_tag !== 4'd6 || rsp_err !== 1'b0)
            bad = 1'b1;
      end
      tests++; if (bad !== 1'b0) begin fails++; $display("FAIL stall_hold: got unstable response (valid %b ready %b res %0d tag %0d) want 1 0 3 6", rsp_valid, cmd_ready, rsp_result, rsp_tag); end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL stall_retire: got valid/ready %b want 01", {rsp_valid, cmd_ready}); end
      tests++; if (issued_cnt !== 16'd7) begin fails++; $display("FAIL stall_issued_cnt: got %0d want 7", issued_cnt); end
   endtask

   task automatic test_reset_mid;
      logic bad;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 32'd1; cmd_b = 32'd1; cmd_op = 4'd0; cmd_tag = 4'd7;
      @(negedge clk);
      cmd_valid = 1'b0;
      tests++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL rmid_issue_enable: got %b want 1", alu_enable); end
      rst_n = 1'b0;
      #1;
      tests++; if ({alu_enable, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rmid_async_enable: got en/ready %b want 01", {alu_enable, cmd_ready}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 32'd4; cmd_b = 32'd4; cmd_op = 4'd0; cmd_tag = 4'd7;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++; if ({rsp_valid, cmd_ready, alu_enable} !== 3'b010) begin fails++; $display("FAIL rmid_wait_reset: got valid/ready/en %b want 010", {rsp_valid, cmd_ready, alu_enable}); end
      tests++; if ({issued_cnt, alu_a} !== 48'd0) begin fails++; $display("FAIL rmid_regs_cleared: got cnt %0d alu_a %h want 0 0", issued_cnt, alu_a); end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
      end
      tests++; if (bad !== 1'b0) begin fails++; $display("FAIL rmid_no_response: got spurious response or busy, want idle"); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ba[4], bb[4], be[4];
      logic [3:0]  bo[4];
      int lat;
      ba[0] = 32'd3;    bb[0] = 32'd4;  bo[0] = 4'd0; be[0] = 32'd7;
      ba[1] = 32'd20;   bb[1] = 32'd5;  bo[1] = 4'd1; be[1] = 32'd15;
      ba[2] = 32'hF0;   bb[2] = 32'h0F; bo[2] = 4'd3; be[2] = 32'hFF;
      ba[3] = 32'h100;  bb[3] = 32'd4;  bo[3] = 4'd6; be[3] = 32'h10;
      @(negedge clk);
      t3_cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         t3_cmd_a = ba[i]; t3_cmd_b = bb[i]; t3_cmd_op = bo[i]; t3_cmd_tag = 4'(i + 1);
         tests++; if (t3_cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b want 1", i, t3_cmd_ready); end
         lat = 99;
         for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (t3_rsp_valid) begin lat = n; break; end
         end
         tests++; if (lat != 5) begin fails++; $display("FAIL b2b_latency_%0d: got %0d want 5", i, lat); end
         tests++; if ({t3_rsp_result, t3_rsp_tag} !== {be[i], 4'(i + 1)})
            begin fails++; $display("FAIL b2b_rsp_%0d: got %h tag %0d want %h tag %0d", i, t3_rsp_result, t3_rsp_tag, be[i], i + 1); end
      end
      @(negedge clk);
      t3_cmd_valid = 1'b0;
      tests++; if (t3_issued_cnt !== 3'd4) begin fails++; $display("FAIL b2b_issued_cnt: got %0d want 4", t3_issued_cnt); end
   endtask

   task automatic test_cnt_wrap;
      int lat;
      for (int i = 0; i < 3; i++) do_cmd3(32'd0, 32'd0, 4'd0, 4'd0, lat);
      @(negedge clk);
      tests++; if (t3_issued_cnt !== 3'd7) begin fails++; $display("FAIL wrap_max: got %0d want 7", t3_issued_cnt); end
      do_cmd3(32'd0, 32'd0, 4'd0, 4'd0, lat);
      tests++; if ({t3_rsp_result, t3_rsp_zero} !== {32'd0, 1'b1}) begin fails++; $display("FAIL wrap_zero_rsp: got %h/%b want 0/1", t3_rsp_result, t3_rsp_zero); end
      @(negedge clk);
      tests++; if (t3_issued_cnt !== 3'd0) begin fails++; $display("FAIL wrap_to_zero: got %0d want 0", t3_issued_cnt); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub_zero;
      test_overflow;
      test_ops;
      test_illegal;
      test_stall;
      test_reset_mid;
      test_back_to_back;
      test_cnt_wrap;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, want completion");
      $fatal(1);
   end

endmodule
